// File: rtl/count_stepper.sv
// count_stepper: turns INC/DEC/SET commands into a paced sequence of single-step requests
// to a BCD up/down counter. It handshakes each step on the counter's Ready line and flags a
// sticky error if any wait state lasts too long.
module count_stepper #(
  parameter int unsigned D_NUM   = 6,
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Cmd_Valid,
  output logic                 Cmd_Ready,
  input  logic [1:0]           Cmd_Op,
  input  logic [STEP_W-1:0]    Cmd_Steps,
  input  logic [D_NUM*4-1:0]   Cmd_Data,
  output logic                 Request,
  output logic                 Dec,
  output logic                 Set,
  output logic [D_NUM*4-1:0]   In,
  input  logic                 Ready,
  output logic                 Done,
  output logic                 Error,
  output logic [STEP_W-1:0]    Remaining
);

  localparam int unsigned DataW = D_NUM * 4;
  // Counter only needs to reach TIMEOUT-1: that is the last cycle a wait state may last.
  localparam int unsigned CntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [1:0] OpInc = 2'b00;
  localparam logic [1:0] OpDec = 2'b01;
  localparam logic [1:0] OpSet = 2'b10;
  localparam logic [1:0] OpNop = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitRdy,
    StFinish,
    StErr
  } state_e;

  state_e               state_q;
  logic                 dec_q;
  logic                 set_q;
  logic                 done_q;
  logic                 error_q;
  logic [DataW-1:0]     in_q;
  logic [STEP_W-1:0]    remaining_q;
  logic [CntW-1:0]      cnt_q;
  logic                 timeout;

  assign timeout = (cnt_q == CntLast);

  // Command sequencing, wait-state watchdog and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= StIdle;
      dec_q       <= 1'b0;
      set_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      in_q        <= '0;
      remaining_q <= '0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (Cmd_Valid) begin
            dec_q <= (Cmd_Op == OpDec);
            set_q <= (Cmd_Op == OpSet);
            in_q  <= (Cmd_Op == OpSet) ? Cmd_Data : '0;
            cnt_q <= '0;
            case (Cmd_Op)
              OpInc, OpDec: remaining_q <= Cmd_Steps;
              OpSet:        remaining_q <= STEP_W'(1);
              default:      remaining_q <= '0;
            endcase
            // Nothing to step: complete immediately without touching the counter.
            if ((Cmd_Op == OpNop) || ((Cmd_Op != OpSet) && (Cmd_Steps == '0))) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          if (Ready) begin
            if (remaining_q != '0) begin
              remaining_q <= remaining_q - 1'b1;
            end
            cnt_q   <= '0;
            state_q <= StWaitAck;
          end else if (timeout) begin
            state_q <= StErr;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitAck: begin
          if (!Ready) begin
            cnt_q   <= '0;
            state_q <= StWaitRdy;
          end else if (timeout) begin
            state_q <= StErr;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitRdy: begin
          if (Ready) begin
            cnt_q <= '0;
            if (remaining_q != '0) begin
              state_q <= StIssue;
            end else begin
              state_q <= StFinish;
              done_q  <= 1'b1;
              set_q   <= 1'b0;
              in_q    <= '0;
            end
          end else if (timeout) begin
            state_q <= StErr;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFinish: begin
          set_q   <= 1'b0;
          in_q    <= '0;
          state_q <= StIdle;
        end
        StErr: begin
          error_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Request follows Ready only while issuing, so it can never outlive the ISSUE state.
  assign Request   = (state_q == StIssue) && Ready;
  assign Cmd_Ready = (state_q == StIdle);
  assign Dec       = dec_q;
  assign Set       = set_q;
  assign In        = in_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign Remaining = remaining_q;

endmodule

// File: tb/tb_count_stepper.sv
// Directed bench for count_stepper with a behavioural BCD counter model on the far side.
module tb_count_stepper;

  localparam int unsigned D_NUM       = 6;
  localparam int unsigned STEP_W      = 8;
  localparam int unsigned TIMEOUT     = 16;
  localparam int          COUNT_DELAY = 3;

  localparam logic [1:0] OpInc = 2'b00;
  localparam logic [1:0] OpDec = 2'b01;
  localparam logic [1:0] OpSet = 2'b10;
  localparam logic [1:0] OpNop = 2'b11;

  logic                Clk = 1'b0;
  logic                Rst_n = 1'b0;
  logic                Cmd_Valid = 1'b0;
  logic                Cmd_Ready;
  logic [1:0]          Cmd_Op = 2'b11;
  logic [STEP_W-1:0]   Cmd_Steps = '0;
  logic [D_NUM*4-1:0]  Cmd_Data = '0;
  logic                Request;
  logic                Dec;
  logic                Set;
  logic [D_NUM*4-1:0]  In;
  logic                Ready = 1'b1;
  logic                Done;
  logic                Error;
  logic [STEP_W-1:0]   Remaining;

  int n_chk = 0;
  int n_err = 0;

  count_stepper #(
    .D_NUM  (D_NUM),
    .STEP_W (STEP_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Cmd_Valid(Cmd_Valid),
    .Cmd_Ready(Cmd_Ready),
    .Cmd_Op   (Cmd_Op),
    .Cmd_Steps(Cmd_Steps),
    .Cmd_Data (Cmd_Data),
    .Request  (Request),
    .Dec      (Dec),
    .Set      (Set),
    .In       (In),
    .Ready    (Ready),
    .Done     (Done),
    .Error    (Error),
    .Remaining(Remaining)
  );

  always #5 Clk = ~Clk;

  // Counter model: a Request drops Ready for COUNT_DELAY cycles, then applies the step.
  logic               no_ack = 1'b0;
  logic               busy = 1'b0;
  int                 dly = 0;
  int                 out_val = 0;
  logic               ld_dec = 1'b0;
  logic               ld_set = 1'b0;
  logic [D_NUM*4-1:0] ld_in = '0;

  function automatic int bcd2int(input logic [D_NUM*4-1:0] v);
    int r = 0;
    for (int i = D_NUM - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  always @(posedge Clk) begin
    if (!Rst_n) begin
      Ready <= 1'b1;
      busy  <= 1'b0;
      dly   <= 0;
    end else if (busy) begin
      if (dly == COUNT_DELAY - 1) begin
        busy  <= 1'b0;
        Ready <= 1'b1;
        if (ld_set) out_val <= bcd2int(ld_in);
        else if (ld_dec) out_val <= out_val - 1;
        else out_val <= out_val + 1;
      end else begin
        dly <= dly + 1;
      end
    end else if (Request && !no_ack) begin
      busy   <= 1'b1;
      Ready  <= 1'b0;
      dly    <= 0;
      ld_dec <= Dec;
      ld_set <= Set;
      ld_in  <= In;
    end
  end

  // Event monitors on the DUT side of the interface.
  int                 req_cnt = 0;
  int                 req_dec = 0;
  int                 req_set = 0;
  int                 consec = 0;
  int                 done_cnt = 0;
  logic               req_prev = 1'b0;
  logic [D_NUM*4-1:0] req_in = '0;

  always @(posedge Clk) begin
    if (Request) begin
      req_cnt <= req_cnt + 1;
      req_in  <= In;
      if (Dec) req_dec <= req_dec + 1;
      if (Set) req_set <= req_set + 1;
    end
    if (Request && req_prev) consec <= consec + 1;
    req_prev <= Request;
    if (Done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Presents one command and returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [STEP_W-1:0] steps,
                      input logic [D_NUM*4-1:0] data);
    Cmd_Op    = op;
    Cmd_Steps = steps;
    Cmd_Data  = data;
    Cmd_Valid = 1'b1;
    chk("accept_ready", 32'(Cmd_Ready), 32'd1);
    tick();
    Cmd_Valid = 1'b0;
    Cmd_Op    = OpNop;
    Cmd_Steps = '0;
    Cmd_Data  = '0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (!Cmd_Ready && n < limit) begin
      tick();
      n++;
    end
    chk(tag, 32'(Cmd_Ready), 32'd1);
  endtask

  int b_req, b_dec, b_set, b_done, n_wait;

  initial begin
    // Reset state
    Rst_n = 1'b0;
    tick();
    tick();
    chk("rst_request", 32'(Request), 32'd0);
    chk("rst_dec", 32'(Dec), 32'd0);
    chk("rst_set", 32'(Set), 32'd0);
    chk("rst_in", 32'(In), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("rst_remaining", 32'(Remaining), 32'd0);
    Rst_n = 1'b1;
    tick();
    chk("rst_cmd_ready", 32'(Cmd_Ready), 32'd1);

    // INC 5 from 0
    b_req = req_cnt; b_dec = req_dec; b_done = done_cnt;
    send(OpInc, 8'd5, '0);
    chk("inc_remaining_latched", 32'(Remaining), 32'd5);
    chk("inc_dec_latched", 32'(Dec), 32'd0);
    wait_idle("inc_idle", 200);
    chk("inc_requests", 32'(req_cnt - b_req), 32'd5);
    chk("inc_dec_during_req", 32'(req_dec - b_dec), 32'd0);
    chk("inc_out", 32'(out_val), 32'd5);
    chk("inc_done_count", 32'(done_cnt - b_done), 32'd1);
    chk("inc_remaining_end", 32'(Remaining), 32'd0);

    // DEC 5 back to 0
    b_req = req_cnt; b_dec = req_dec; b_done = done_cnt;
    send(OpDec, 8'd5, '0);
    chk("dec_dec_latched", 32'(Dec), 32'd1);
    wait_idle("dec_idle", 200);
    chk("dec_requests", 32'(req_cnt - b_req), 32'd5);
    chk("dec_dec_during_req", 32'(req_dec - b_dec), 32'd5);
    chk("dec_out", 32'(out_val), 32'd0);
    chk("dec_done_count", 32'(done_cnt - b_done), 32'd1);

    // SET 39 then DEC 39
    b_req = req_cnt; b_set = req_set; b_done = done_cnt;
    send(OpSet, 8'd0, 24'h000039);
    chk("set_remaining_latched", 32'(Remaining), 32'd1);
    chk("set_in_latched", 32'(In), 32'h39);
    wait_idle("set_idle", 200);
    chk("set_requests", 32'(req_cnt - b_req), 32'd1);
    chk("set_set_during_req", 32'(req_set - b_set), 32'd1);
    chk("set_in_during_req", 32'(req_in), 32'h39);
    chk("set_out", 32'(out_val), 32'd39);
    chk("set_set_cleared", 32'(Set), 32'd0);
    chk("set_in_cleared", 32'(In), 32'd0);
    b_req = req_cnt;
    send(OpDec, 8'd39, '0);
    wait_idle("dec39_idle", 2000);
    chk("dec39_requests", 32'(req_cnt - b_req), 32'd39);
    chk("dec39_out", 32'(out_val), 32'd0);
    chk("set_dec39_done_count", 32'(done_cnt - b_done), 32'd2);

    // INC 0 and NOP complete one cycle after acceptance, no Request
    b_req = req_cnt;
    send(OpInc, 8'd0, '0);
    chk("inc0_done_next", 32'(Done), 32'd1);
    tick();
    chk("inc0_done_single", 32'(Done), 32'd0);
    chk("inc0_idle", 32'(Cmd_Ready), 32'd1);
    send(OpNop, 8'd7, 24'h000012);
    chk("nop_done_next", 32'(Done), 32'd1);
    chk("nop_remaining", 32'(Remaining), 32'd0);
    tick();
    chk("nop_done_single", 32'(Done), 32'd0);
    chk("inc0_nop_requests", 32'(req_cnt - b_req), 32'd0);

    // Reset during WAIT_RDY of INC 10
    b_req = req_cnt; b_done = done_cnt;
    send(OpInc, 8'd10, '0);
    n_wait = 0;
    while (req_cnt == b_req && n_wait < 20) begin
      tick();
      n_wait++;
    end
    chk("midrst_first_req", 32'(req_cnt - b_req), 32'd1);
    tick();
    chk("midrst_in_wait_rdy", 32'(Ready), 32'd0);
    Cmd_Valid = 1'b1;
    Cmd_Op    = OpDec;
    Cmd_Steps = 8'd3;
    tick();
    Cmd_Valid = 1'b0;
    Cmd_Op    = OpNop;
    Cmd_Steps = '0;
    chk("ignored_cmd_remaining", 32'(Remaining), 32'd9);
    chk("ignored_cmd_dec", 32'(Dec), 32'd0);
    Rst_n = 1'b0;
    tick();
    chk("midrst_request", 32'(Request), 32'd0);
    chk("midrst_remaining", 32'(Remaining), 32'd0);
    chk("midrst_dec", 32'(Dec), 32'd0);
    chk("midrst_set", 32'(Set), 32'd0);
    chk("midrst_in", 32'(In), 32'd0);
    chk("midrst_error", 32'(Error), 32'd0);
    Rst_n = 1'b1;
    tick();
    tick();
    chk("midrst_no_done", 32'(done_cnt - b_done), 32'd0);
    b_req = req_cnt;
    send(OpInc, 8'd2, '0);
    wait_idle("post_rst_idle", 200);
    chk("post_rst_requests", 32'(req_cnt - b_req), 32'd2);
    chk("post_rst_done", 32'(done_cnt - b_done), 32'd1);

    // Counter never acknowledges: watchdog must trip
    no_ack = 1'b1;
    b_req = req_cnt;
    send(OpInc, 8'd3, '0);
    n_wait = 0;
    while (!Error && n_wait < 40) begin
      tick();
      n_wait++;
    end
    chk("timeout_error", 32'(Error), 32'd1);
    chk("timeout_latency_le17", 32'(n_wait <= 17), 32'd1);
    repeat (10) tick();
    chk("timeout_sticky", 32'(Error), 32'd1);
    chk("timeout_requests", 32'(req_cnt - b_req), 32'd1);
    chk("timeout_cmd_ready", 32'(Cmd_Ready), 32'd0);
    chk("timeout_no_consecutive_req", 32'(consec), 32'd0);
    no_ack = 1'b0;
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();
    chk("timeout_rst_error", 32'(Error), 32'd0);
    chk("timeout_rst_cmd_ready", 32'(Cmd_Ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
